seq_detect_param: RTL and testbench

Parametrised serial-bit sequence detector. It is the successor to the fixed-pattern single-bit FSM detector. Pattern width, pattern value and overlap mode are configurable, bits are qualified by a valid strobe, and a saturating match counter is included. It sits between a serial data source and control logic that needs a one-cycle match pulse plus a running match count.

---
 rtl/seq_detect_param.sv | 107 ++++++++++
 tb/tb_seq_detect_param.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_param.sv
// Parametrised serial-bit sequence detector: valid-qualified bits, configurable
// pattern/overlap, one-cycle registered match pulse and saturating match counter.
module seq_detect_param #(
  parameter int unsigned      PAT_W        = 4,
  parameter logic [PAT_W-1:0] PATTERN_INIT = 4'b1101,
  parameter logic             OVERLAP_INIT = 1'b1,
  parameter int unsigned      CNT_W        = 8
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             en,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic             cfg_overlap,
  input  logic             cnt_clr,
  input  logic             in_valid,
  input  logic             in,
  output logic             out,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat,
  output logic [1:0]       state
);

  localparam int unsigned FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_DETECT = 2'd2
  } state_t;

  state_t             state_q;
  logic [PAT_W-1:0]   window;
  logic [FILL_W-1:0]  fill;
  logic [PAT_W-1:0]   pattern_q;
  logic               overlap_q;

  logic               accept;
  logic [PAT_W-1:0]   win_nxt;
  logic [FILL_W-1:0]  fill_nxt;
  logic               full_nxt;
  logic               hit;
  logic [CNT_W-1:0]   cnt_nxt;

  assign state = state_q;

  // Candidate window/fill for an accepted bit and the resulting match decision
  always_comb begin
    accept   = en && !cfg_load && in_valid;
    win_nxt  = {window[PAT_W-2:0], in};
    fill_nxt = (fill == FILL_FULL) ? fill : fill + FILL_W'(1);
    full_nxt = (fill_nxt == FILL_FULL);
    hit      = accept && full_nxt && (win_nxt == pattern_q);
    if (cnt_clr) begin
      cnt_nxt = CNT_W'(hit);
    end else if (hit && !cnt_sat) begin
      cnt_nxt = match_cnt + CNT_W'(1);
    end else begin
      cnt_nxt = match_cnt;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q   <= ST_IDLE;
      window    <= '0;
      fill      <= '0;
      pattern_q <= PATTERN_INIT;
      overlap_q <= OVERLAP_INIT;
      out       <= 1'b0;
      match_cnt <= '0;
      cnt_sat   <= 1'b0;
    end else begin
      out <= hit;
      if (cfg_load) begin
        pattern_q <= cfg_pattern;
        overlap_q <= cfg_overlap;
      end
      // Disable or reconfiguration discards any partial match
      if (!en) begin
        state_q <= ST_IDLE;
        window  <= '0;
        fill    <= '0;
      end else if (cfg_load) begin
        state_q <= ST_FILL;
        window  <= '0;
        fill    <= '0;
      end else if (accept) begin
        if (hit && !overlap_q) begin
          state_q <= ST_FILL;
          window  <= '0;
          fill    <= '0;
        end else begin
          state_q <= full_nxt ? ST_DETECT : ST_FILL;
          window  <= win_nxt;
          fill    <= fill_nxt;
        end
      end else if (state_q == ST_IDLE) begin
        state_q <= ST_FILL;
      end
      match_cnt <= cnt_nxt;
      cnt_sat   <= &cnt_nxt;
    end
  end

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: directed scenarios plus random traffic, all
// checked every cycle against a queue-based model of accepted bits.
module tb_seq_detect_param;

  localparam int unsigned PAT_W = 4;

  logic             sys_clk = 1'b0;
  logic             sys_rst = 1'b1;
  logic             en = 1'b0;
  logic             cfg_load = 1'b0;
  logic [PAT_W-1:0] cfg_pattern = '0;
  logic             cfg_overlap = 1'b0;
  logic             cnt_clr = 1'b0;
  logic             in_valid = 1'b0;
  logic             in = 1'b0;

  logic       out, out2, cnt_sat, cnt_sat2;
  logic [7:0] match_cnt;
  logic [1:0] match_cnt2;
  logic [1:0] state, state2;

  seq_detect_param u_dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .en(en), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
    .in_valid(in_valid), .in(in), .out(out), .match_cnt(match_cnt),
    .cnt_sat(cnt_sat), .state(state)
  );

  seq_detect_param #(.CNT_W(2)) u_dut2 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .en(en), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
    .in_valid(in_valid), .in(in), .out(out2), .match_cnt(match_cnt2),
    .cnt_sat(cnt_sat2), .state(state2)
  );

  always #5 sys_clk = ~sys_clk;

  int total = 0;
  int bad = 0;
  int pulse_cnt = 0;
  bit chk_on = 1'b0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
    end
  endfunction

  // Reference model: history of accepted bits since the last clear
  bit               hist[$];
  logic [PAT_W-1:0] m_pat;
  bit               m_ovl;
  bit               m_idle;
  bit               m_match;
  int               exp_out, exp_state, exp_cnt8, exp_cnt2;

  always @(posedge sys_clk) begin
    m_match = 1'b0;
    if (sys_rst) begin
      hist.delete();
      m_pat = 4'b1101;
      m_ovl = 1'b1;
      m_idle = 1'b1;
      exp_cnt8 = 0;
      exp_cnt2 = 0;
    end else begin
      if (cfg_load) begin
        m_pat = cfg_pattern;
        m_ovl = cfg_overlap;
      end
      if (!en) begin
        hist.delete();
        m_idle = 1'b1;
      end else begin
        m_idle = 1'b0;
        if (cfg_load) begin
          hist.delete();
        end else if (in_valid) begin
          hist.push_back(in);
          if (hist.size() > PAT_W) void'(hist.pop_front());
          if (hist.size() == PAT_W) begin
            m_match = 1'b1;
            for (int i = 0; i < PAT_W; i++)
              if (hist[i] != m_pat[PAT_W-1-i]) m_match = 1'b0;
            if (m_match && !m_ovl) hist.delete();
          end
        end
      end
      if (cnt_clr) begin
        exp_cnt8 = int'(m_match);
        exp_cnt2 = int'(m_match);
      end else begin
        exp_cnt8 = (exp_cnt8 + int'(m_match) > 255) ? 255 : exp_cnt8 + int'(m_match);
        exp_cnt2 = (exp_cnt2 + int'(m_match) > 3) ? 3 : exp_cnt2 + int'(m_match);
      end
    end
    exp_out = int'(m_match);
    exp_state = m_idle ? 0 : ((hist.size() == PAT_W) ? 2 : 1);
  end

  always @(negedge sys_clk) begin
    if (chk_on) begin
      chk("out", 32'(out), 32'(exp_out));
      chk("out2", 32'(out2), 32'(exp_out));
      chk("state", 32'(state), 32'(exp_state));
      chk("state2", 32'(state2), 32'(exp_state));
      chk("cnt8", 32'(match_cnt), 32'(exp_cnt8));
      chk("sat8", 32'(cnt_sat), 32'(exp_cnt8 == 255));
      chk("cnt2", 32'(match_cnt2), 32'(exp_cnt2));
      chk("sat2", 32'(cnt_sat2), 32'(exp_cnt2 == 3));
      if (out === 1'b1) pulse_cnt++;
    end
  end

  task automatic drive(input bit v, input bit b, input bit ld, input bit clr,
                       input bit e, input bit rst);
    @(negedge sys_clk);
    in_valid = v; in = b; cfg_load = ld; cnt_clr = clr; en = e; sys_rst = rst;
  endtask

  task automatic send(input bit b);
    drive(1'b1, b, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic gap();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic settle();
    gap();
    gap();
  endtask

  task automatic send4(input logic [3:0] bits);
    for (int i = 3; i >= 0; i--) send(bits[i]);
  endtask

  int p0;

  initial begin
    repeat (2) @(negedge sys_clk);
    chk_on = 1'b1;
    sys_rst = 1'b0;
    en = 1'b1;
    chk("rst_out", 32'(out), 0);
    chk("rst_state", 32'(state), 0);
    chk("rst_cnt", 32'(match_cnt), 0);
    settle();

    // 1: overlapping 1101 in 1101101
    p0 = pulse_cnt;
    send4(4'b1101);
    send(1'b1);
    chk("t1_out_b4", 32'(out), 1);
    send(1'b0);
    send(1'b1);
    settle();
    chk("t1_pulses", 32'(pulse_cnt - p0), 2);
    chk("t1_cnt", 32'(match_cnt), 2);

    // 2: non-overlapping
    cfg_pattern = 4'b1101; cfg_overlap = 1'b0;
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    p0 = pulse_cnt;
    send4(4'b1101);
    send(1'b1); send(1'b0); send(1'b1);
    settle();
    chk("t2_pulses", 32'(pulse_cnt - p0), 1);
    chk("t2_cnt", 32'(match_cnt), 1);
    chk("t2_state", 32'(state), 1);

    // 3: valid gaps hold a partial match
    cfg_overlap = 1'b1;
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    p0 = pulse_cnt;
    send(1'b1); send(1'b1);
    gap(); gap(); gap();
    send(1'b0); send(1'b1);
    settle();
    chk("t3_pulses", 32'(pulse_cnt - p0), 1);

    // 4: 2-bit counter saturation, then clear coincident with a match
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    send4(4'b1101);
    for (int k = 0; k < 4; k++) begin
      send(1'b1); send(1'b0); send(1'b1);
      if (k == 1) begin
        gap();
        chk("t4_cnt2_m3", 32'(match_cnt2), 3);
        chk("t4_sat2_m3", 32'(cnt_sat2), 1);
      end
    end
    settle();
    chk("t4_cnt2", 32'(match_cnt2), 3);
    chk("t4_cnt8", 32'(match_cnt), 5);
    send(1'b1); send(1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    gap();
    chk("t4_clr_cnt2", 32'(match_cnt2), 1);
    chk("t4_clr_sat2", 32'(cnt_sat2), 0);
    chk("t4_clr_cnt8", 32'(match_cnt), 1);

    // 5: load 0110 while a bit is offered
    cfg_pattern = 4'b0110; cfg_overlap = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    p0 = pulse_cnt;
    send(1'b0);
    chk("t5_state", 32'(state), 1);
    send(1'b1); send(1'b1); send(1'b0);
    settle();
    chk("t5_pulses", 32'(pulse_cnt - p0), 1);
    p0 = pulse_cnt;
    send4(4'b1101);
    settle();
    chk("t5_no_pulse", 32'(pulse_cnt - p0), 0);

    // 6: reset and disable clear partial matches
    send(1'b1); send(1'b1); send(1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    gap();
    chk("t6_out", 32'(out), 0);
    chk("t6_state", 32'(state), 0);
    chk("t6_cnt", 32'(match_cnt), 0);
    chk("t6_sat", 32'(cnt_sat), 0);
    p0 = pulse_cnt;
    send4(4'b1101);
    settle();
    chk("t6_pat_init", 32'(pulse_cnt - p0), 1);
    p0 = pulse_cnt;
    send(1'b1); send(1'b1); send(1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    send(1'b1);
    settle();
    chk("t6_en_clear", 32'(pulse_cnt - p0), 0);
    p0 = pulse_cnt;
    send4(4'b1101);
    settle();
    chk("t6_after_en", 32'(pulse_cnt - p0), 1);

    // Random traffic
    for (int n = 0; n < 4000; n++) begin
      cfg_pattern = 4'($urandom_range(0, 15));
      cfg_overlap = 1'($urandom_range(0, 1));
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 39) == 0),
            1'($urandom_range(0, 19) != 0), 1'($urandom_range(0, 199) == 0));
    end
    settle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
